// File: rtl/ppm_data_if.sv
// Payload byte stream between the frame source and the PPM modulator.
interface ppm_data_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/ppm_data_mod.sv
// PPM payload modulator: buffers one payload byte, then after the SOF stage
// completes emits each byte as MSB-first M-bit pulse-position symbols.
module ppm_data_mod #(
    parameter int unsigned BITS_PER_SYM = 2,
    parameter int unsigned SLOT_CLKS    = 4,
    parameter int unsigned PULSE_CLKS   = 1,
    parameter int unsigned GUARD_SLOTS  = 1,
    parameter int unsigned FRAME_BYTES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sof_done,
    ppm_data_if.slave  bus,
    output logic       ppm_out,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    localparam int unsigned SLOTS         = 1 << BITS_PER_SYM;
    localparam int unsigned SLOT_TOT      = SLOTS + GUARD_SLOTS;
    localparam int unsigned SYMS_PER_BYTE = 8 / BITS_PER_SYM;
    localparam int unsigned CIS_W         = $clog2(SLOT_CLKS);
    localparam int unsigned SLOT_W        = $clog2(SLOT_TOT + 1);
    localparam int unsigned SIDX_W        = $clog2(SYMS_PER_BYTE + 1);
    localparam int unsigned CNT_W         = 8;

    typedef enum logic [1:0] {S_IDLE, S_SYM, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [7:0]              shreg, shreg_nxt;
    logic [7:0]              buf_data, buf_data_nxt;
    logic                    buf_full, buf_full_nxt;
    logic [CNT_W-1:0]        fetched, fetched_nxt;
    logic [CNT_W-1:0]        byte_cnt, byte_cnt_nxt;
    logic [SIDX_W-1:0]       sym_idx, sym_idx_nxt;
    logic [SLOT_W-1:0]       slot, slot_nxt;
    logic [CIS_W-1:0]        cis, cis_nxt;
    logic                    ppm_nxt, busy_nxt, frame_done_nxt, underrun_nxt;
    logic                    data_ready_q, data_ready_nxt;
    logic                    accept_c;
    logic [BITS_PER_SYM-1:0] sym_c;

    assign accept_c       = bus.data_valid & data_ready_q;
    assign sym_c          = shreg[7 -: BITS_PER_SYM];
    assign bus.data_ready = data_ready_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state, buffer handshake, symbol counters and output next-values.
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        buf_data_nxt   = buf_data;
        buf_full_nxt   = buf_full;
        fetched_nxt    = fetched;
        byte_cnt_nxt   = byte_cnt;
        sym_idx_nxt    = sym_idx;
        slot_nxt       = slot;
        cis_nxt        = cis;
        ppm_nxt        = 1'b0;
        busy_nxt       = busy;
        frame_done_nxt = 1'b0;
        underrun_nxt   = 1'b0;

        if (accept_c) begin
            buf_full_nxt = 1'b1;
            buf_data_nxt = bus.data_in;
            fetched_nxt  = fetched + CNT_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (sof_done) begin
                    if (buf_full) begin
                        shreg_nxt    = buf_data;
                        buf_full_nxt = accept_c;
                        byte_cnt_nxt = CNT_W'(1);
                        sym_idx_nxt  = '0;
                        slot_nxt     = '0;
                        cis_nxt      = '0;
                        busy_nxt     = 1'b1;
                        state_nxt    = S_SYM;
                    end else begin
                        // Starved start: any byte landing on this edge is dropped.
                        underrun_nxt = 1'b1;
                        buf_full_nxt = 1'b0;
                        fetched_nxt  = '0;
                    end
                end
            end
            S_SYM: begin
                ppm_nxt = (slot == SLOT_W'(sym_c)) && (cis < CIS_W'(PULSE_CLKS));
                cis_nxt = cis + CIS_W'(1);
                if (cis == CIS_W'(SLOT_CLKS - 1)) begin
                    cis_nxt  = '0;
                    slot_nxt = slot + SLOT_W'(1);
                    if (slot == SLOT_W'(SLOT_TOT - 1)) begin
                        slot_nxt    = '0;
                        sym_idx_nxt = sym_idx + SIDX_W'(1);
                        shreg_nxt   = 8'(shreg << BITS_PER_SYM);
                        if (sym_idx == SIDX_W'(SYMS_PER_BYTE - 1)) begin
                            sym_idx_nxt = '0;
                            if (byte_cnt == CNT_W'(FRAME_BYTES)) begin
                                state_nxt = S_DONE;
                            end else if (buf_full) begin
                                // Seamless reload: next symbol starts on the next clock.
                                shreg_nxt    = buf_data;
                                buf_full_nxt = accept_c;
                                byte_cnt_nxt = byte_cnt + CNT_W'(1);
                            end else begin
                                underrun_nxt = 1'b1;
                                ppm_nxt      = 1'b0;
                                busy_nxt     = 1'b0;
                                buf_full_nxt = 1'b0;
                                fetched_nxt  = '0;
                                state_nxt    = S_IDLE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                frame_done_nxt = 1'b1;
                busy_nxt       = 1'b0;
                fetched_nxt    = '0;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        data_ready_nxt = !buf_full_nxt && (fetched_nxt < CNT_W'(FRAME_BYTES));
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg        <= '0;
            buf_data     <= '0;
            buf_full     <= 1'b0;
            fetched      <= '0;
            byte_cnt     <= '0;
            sym_idx      <= '0;
            slot         <= '0;
            cis          <= '0;
            ppm_out      <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            shreg        <= shreg_nxt;
            buf_data     <= buf_data_nxt;
            buf_full     <= buf_full_nxt;
            fetched      <= fetched_nxt;
            byte_cnt     <= byte_cnt_nxt;
            sym_idx      <= sym_idx_nxt;
            slot         <= slot_nxt;
            cis          <= cis_nxt;
            ppm_out      <= ppm_nxt;
            busy         <= busy_nxt;
            frame_done   <= frame_done_nxt;
            underrun     <= underrun_nxt;
            data_ready_q <= data_ready_nxt;
        end
    end
endmodule

// File: tb/tb_ppm_data_mod.sv
// Bench for ppm_data_mod: frame-position reference model plus directed scenarios.
module tb_ppm_data_mod;
    localparam int M         = 2;
    localparam int SC        = 4;
    localparam int PC        = 1;
    localparam int G         = 1;
    localparam int FB        = 2;
    localparam int SLOTS     = 1 << M;
    localparam int SYM_CLKS  = (SLOTS + G) * SC;
    localparam int BYTE_CLKS = (8 / M) * SYM_CLKS;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic sof_done = 1'b0;
    logic ppm_out, busy, frame_done, underrun;

    ppm_data_if bus();

    ppm_data_mod #(
        .BITS_PER_SYM(M), .SLOT_CLKS(SC), .PULSE_CLKS(PC),
        .GUARD_SLOTS(G), .FRAME_BYTES(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sof_done(sof_done), .bus(bus),
        .ppm_out(ppm_out), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int src_pct  = 100;
    int hs_cnt   = 0;
    bit chk_en   = 1'b0;
    logic [7:0] src_q[$];
    int pulses[$];
    int exp_s1[8] = '{12, 28, 44, 60, 80, 104, 128, 152};

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Payload source: offers queued bytes, holds each until the handshake completes.
    initial begin
        bit hs;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        forever begin
            @(negedge clk);
            hs = bus.data_valid && bus.data_ready;
            @(posedge clk);
            #1;
            if (bus.data_valid && !hs) begin
                bus.data_valid = 1'b1;
            end else if (src_q.size() > 0 && int'($urandom_range(0, 99)) < src_pct) begin
                bus.data_valid = 1'b1;
                bus.data_in    = src_q.pop_front();
            end else begin
                bus.data_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) if (bus.data_valid && bus.data_ready) hs_cnt++;

    // Reference model: frame tracked as an absolute clock position within the frame.
    logic [7:0] m_buf[$];
    logic [7:0] m_cur    = 8'h00;
    int  m_fetched = 0, m_pos = 0, m_nbytes = 0;
    bit  m_active = 1'b0, m_done = 1'b0;
    bit  acc, drop;
    int  ms, mslot, mcis, msv;
    logic e_ppm = 1'b0, e_busy = 1'b0, e_fd = 1'b0, e_und = 1'b0, e_rdy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_buf.delete();
            m_fetched = 0; m_active = 1'b0; m_done = 1'b0; m_pos = 0; m_nbytes = 0;
            e_ppm = 1'b0; e_busy = 1'b0; e_fd = 1'b0; e_und = 1'b0; e_rdy = 1'b0;
        end else begin
            acc   = bus.data_valid && e_rdy;
            drop  = 1'b0;
            e_ppm = 1'b0; e_fd = 1'b0; e_und = 1'b0;
            if (m_done) begin
                m_done = 1'b0; e_fd = 1'b1; e_busy = 1'b0; m_fetched = 0;
            end else if (!m_active) begin
                if (sof_done) begin
                    if (m_buf.size() > 0) begin
                        m_cur = m_buf.pop_front();
                        m_active = 1'b1; m_pos = 0; m_nbytes = 1; e_busy = 1'b1;
                    end else begin
                        e_und = 1'b1; m_fetched = 0; drop = 1'b1;
                    end
                end
            end else begin
                ms    = (m_pos % BYTE_CLKS) / SYM_CLKS;
                mslot = (m_pos % SYM_CLKS) / SC;
                mcis  = m_pos % SC;
                msv   = int'(m_cur >> (8 - M * (ms + 1))) & (SLOTS - 1);
                e_ppm = (mslot == msv) && (mcis < PC);
                if (m_pos % BYTE_CLKS == BYTE_CLKS - 1) begin
                    if (m_nbytes == FB) begin
                        m_active = 1'b0; m_done = 1'b1;
                    end else if (m_buf.size() > 0) begin
                        m_cur = m_buf.pop_front(); m_nbytes++; m_pos++;
                    end else begin
                        e_und = 1'b1; e_ppm = 1'b0; e_busy = 1'b0;
                        m_active = 1'b0; m_fetched = 0; drop = 1'b1;
                    end
                end else begin
                    m_pos++;
                end
            end
            if (acc && !drop) begin
                m_buf.push_back(bus.data_in);
                m_fetched++;
            end
            e_rdy = (m_buf.size() == 0) && (m_fetched < FB);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ppm_out",    int'(ppm_out),        int'(e_ppm));
            check("busy",       int'(busy),           int'(e_busy));
            check("frame_done", int'(frame_done),     int'(e_fd));
            check("underrun",   int'(underrun),       int'(e_und));
            check("data_ready", int'(bus.data_ready), int'(e_rdy));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_sof();
        sof_done = 1'b1;
        tick(1);
        sof_done = 1'b0;
        t0 = cyc;
    endtask

    function automatic int exp_pulse(input logic [7:0] b, input int bi, input int s);
        int v;
        v = int'(b >> (8 - M * (s + 1))) & (SLOTS - 1);
        return bi * BYTE_CLKS + s * SYM_CLKS + v * SC;
    endfunction

    // Runs one frame attempt; records pulse positions and event times relative to sof.
    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                             input int mid_sof, output int fd_rel, output int ur_rel);
        if (nbytes > 0) src_q.push_back(b0);
        if (nbytes > 1) src_q.push_back(b1);
        tick(4);
        pulse_sof();
        pulses.delete();
        fd_rel = -1;
        ur_rel = -1;
        for (int i = 0; i < 175; i++) begin
            @(negedge clk);
            sof_done = (i == mid_sof);
            if (ppm_out) pulses.push_back(cyc - t0 - 1);
            if (frame_done && fd_rel < 0) fd_rel = cyc - t0;
            if (underrun && ur_rel < 0) ur_rel = cyc - t0;
        end
        sof_done = 1'b0;
        tick(1);
    endtask

    task automatic check_pulses(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                input int nbytes);
        check({tag, "_npulse"}, pulses.size(), nbytes * (8 / M));
        for (int i = 0; i < pulses.size() && i < nbytes * (8 / M); i++)
            check({tag, "_pos"}, pulses[i], exp_pulse((i < 8 / M) ? b0 : b1, i / (8 / M), i % (8 / M)));
    endtask

    initial begin
        int fd, ur;
        logic [7:0] r0, r1;
        int nb;

        // Reset state
        #2;
        check("rst_ppm", int'(ppm_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(bus.data_ready), 0);
        tick(2);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(2);
        check("ready_after_rst", int'(bus.data_ready), 1);

        // Nominal two-byte frame
        run_frame(8'hE4, 8'h1B, 2, -1, fd, ur);
        check("s1_npulse", pulses.size(), 8);
        for (int i = 0; i < 8 && i < pulses.size(); i++) check("s1_pos", pulses[i], exp_s1[i]);
        check("s1_fd_time", fd, 161);
        check("s1_no_underrun", ur, -1);

        // Start with an empty buffer
        pulse_sof();
        @(negedge clk);
        check("s2_underrun", int'(underrun), 1);
        check("s2_busy", int'(busy), 0);
        tick(5);

        // Only one byte supplied
        r0 = 8'($urandom);
        run_frame(r0, 8'h00, 1, -1, fd, ur);
        check_pulses("s3", r0, 8'h00, 1);
        check("s3_ur_time", ur, 80);
        check("s3_no_fd", fd, -1);
        check("s3_busy_low", int'(busy), 0);

        // Backpressure with valid held high
        src_pct = 100;
        hs_cnt  = 0;
        src_q.push_back(8'($urandom));
        src_q.push_back(8'($urandom));
        tick(4);
        repeat (4) begin
            @(negedge clk);
            check("s4_ready_bp", int'(bus.data_ready), 0);
        end
        tick(1);
        pulse_sof();
        tick(170);
        check("s4_xfers", hs_cnt, FB);

        // sof_done mid-frame is ignored; back-to-back frame afterwards
        r0 = 8'($urandom); r1 = 8'($urandom);
        run_frame(r0, r1, 2, 50, fd, ur);
        check_pulses("s5a", r0, r1, 2);
        check("s5a_fd_time", fd, 161);
        r0 = 8'($urandom); r1 = 8'($urandom);
        run_frame(r0, r1, 2, -1, fd, ur);
        check_pulses("s5b", r0, r1, 2);
        check("s5b_fd_time", fd, 161);

        // Asynchronous reset mid-symbol
        src_q.push_back(8'hE4);
        src_q.push_back(8'h1B);
        tick(4);
        pulse_sof();
        tick(30);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_ppm", int'(ppm_out), 0);
        check("s6_busy", int'(busy), 0);
        check("s6_fd", int'(frame_done), 0);
        check("s6_ur", int'(underrun), 0);
        check("s6_ready", int'(bus.data_ready), 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        run_frame(8'hE4, 8'h1B, 2, -1, fd, ur);
        check("s6_npulse", pulses.size(), 8);
        for (int i = 0; i < 8 && i < pulses.size(); i++) check("s6_pos", pulses[i], exp_s1[i]);
        check("s6_fd_time", fd, 161);

        // Randomized frames, source rates, starvation and stray sof pulses
        for (int it = 0; it < 25; it++) begin
            src_pct = int'($urandom_range(40, 100));
            nb      = int'($urandom_range(0, 2));
            for (int k = 0; k < nb; k++) src_q.push_back(8'($urandom));
            tick(int'($urandom_range(0, 6)));
            pulse_sof();
            for (int i = 0; i < 175; i++) begin
                @(negedge clk);
                sof_done = ($urandom_range(0, 49) == 0);
            end
            sof_done = 1'b0;
            tick(1);
        end

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
